proc_datapath: RTL and testbench

- Execution datapath that responds to the 16-bit processor controller's control word. It holds the program counter, instruction register, 16x16 register file, 256x16 data memory and ALU.
- It presents the current PC to an external instruction ROM and returns IR to the controller.
- Every action in the block is commanded by the controller's strobes. The block never sequences anything itself.

---
 rtl/proc_datapath_if.sv | 45 ++++
 rtl/proc_datapath.sv | 146 ++++++++++++++
 tb/tb_proc_datapath.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/proc_datapath_if.sv
// Control/status bundle between the 16-bit processor controller (master) and its
// execution datapath (slave). Signal names match the controller's control word.
interface proc_datapath_if #(
    parameter int PC_W = 7
);
    // controller -> datapath strobes and addresses
    logic            PC_clr;
    logic            PC_up;
    logic            IR_Id;
    logic [7:0]      D_addr;
    logic            D_wr;
    logic            RF_s;
    logic [3:0]      RF_W_addr;
    logic            RF_W_en;
    logic [3:0]      RF_Ra_addr;
    logic [3:0]      RF_Rb_addr;
    logic [2:0]      ALU_s0;

    // instruction ROM return path and data-memory preload port
    logic [15:0]     I_data;
    logic            dbg_wr;
    logic [7:0]      dbg_addr;
    logic [15:0]     dbg_data;

    // datapath -> controller / ROM
    logic [PC_W-1:0] I_addr;
    logic [15:0]     IR;
    logic [15:0]     Ra_data;
    logic [15:0]     Rb_data;
    logic [15:0]     ALU_out;
    logic            ALU_zero;
    logic [15:0]     R_data;

    modport master (
        output PC_clr, PC_up, IR_Id, D_addr, D_wr, RF_s, RF_W_addr, RF_W_en,
               RF_Ra_addr, RF_Rb_addr, ALU_s0, I_data, dbg_wr, dbg_addr, dbg_data,
        input  I_addr, IR, Ra_data, Rb_data, ALU_out, ALU_zero, R_data
    );

    modport slave (
        input  PC_clr, PC_up, IR_Id, D_addr, D_wr, RF_s, RF_W_addr, RF_W_en,
               RF_Ra_addr, RF_Rb_addr, ALU_s0, I_data, dbg_wr, dbg_addr, dbg_data,
        output I_addr, IR, Ra_data, Rb_data, ALU_out, ALU_zero, R_data
    );
endinterface

// File: rtl/proc_datapath.sv
// Execution datapath: PC, IR, 16x16 register file, 256x16 data memory and ALU.
// Purely strobe-driven; every state change is commanded by the controller.
module proc_datapath #(
    parameter int PC_W = 7
) (
    input  logic          clk,
    input  logic          Reset,
    proc_datapath_if.slave bus
);

    localparam int RF_N  = 16;
    localparam int MEM_N = 256;

    // ------------------------------------------------------------------
    // Program counter and instruction register
    // ------------------------------------------------------------------
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     ir_q, ir_d;

    always_comb begin
        pc_d = pc_q;
        if (bus.PC_clr) begin
            pc_d = '0;
        end else if (bus.PC_up) begin
            pc_d = pc_q + PC_W'(1);
        end
    end

    // I_data is the ROM word at the current (pre-increment) PC.
    always_comb begin
        ir_d = ir_q;
        if (bus.IR_Id) begin
            ir_d = bus.I_data;
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            pc_q <= '0;
            ir_q <= '0;
        end else begin
            pc_q <= pc_d;
            ir_q <= ir_d;
        end
    end

    assign bus.I_addr = pc_q;
    assign bus.IR     = ir_q;

    // ------------------------------------------------------------------
    // Register file: asynchronous reads, no write-to-read bypass
    // ------------------------------------------------------------------
    logic [15:0]     rf_q [RF_N];
    logic [RF_N-1:0] rf_we;
    logic [15:0]     rf_wdata;
    logic [15:0]     alu_result;
    logic [15:0]     rdata_q;

    assign rf_wdata = bus.RF_s ? rdata_q : alu_result;

    genvar gi;
    generate
        for (gi = 0; gi < RF_N; gi++) begin : g_rf_we
            assign rf_we[gi] = bus.RF_W_en && (bus.RF_W_addr == 4'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < RF_N; i++) begin
            if (Reset) begin
                rf_q[i] <= '0;
            end else if (rf_we[i]) begin
                rf_q[i] <= rf_wdata;
            end
        end
    end

    assign bus.Ra_data = rf_q[bus.RF_Ra_addr];
    assign bus.Rb_data = rf_q[bus.RF_Rb_addr];

    // ------------------------------------------------------------------
    // Data memory: synchronous read, old data on read-during-write
    // ------------------------------------------------------------------
    logic [15:0] mem_q [MEM_N];
    logic        mem_we;
    logic [7:0]  mem_waddr;
    logic [15:0] mem_wdata;

    // A datapath store beats the preload port; both are blocked during Reset.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = bus.D_addr;
        mem_wdata = bus.Ra_data;
        if (!Reset) begin
            if (bus.D_wr) begin
                mem_we = 1'b1;
            end else if (bus.dbg_wr) begin
                mem_we    = 1'b1;
                mem_waddr = bus.dbg_addr;
                mem_wdata = bus.dbg_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem_q[bus.D_addr];
        end
    end

    assign bus.R_data = rdata_q;

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    logic [15:0] alu_a, alu_b;

    assign alu_a = bus.Ra_data;
    assign alu_b = bus.Rb_data;

    always_comb begin
        alu_result = '0;
        case (bus.ALU_s0)
            3'b000:  alu_result = '0;
            3'b001:  alu_result = alu_a + alu_b;
            3'b010:  alu_result = alu_a - alu_b;
            3'b011:  alu_result = alu_a;
            3'b100:  alu_result = alu_a & alu_b;
            3'b101:  alu_result = alu_a | alu_b;
            3'b110:  alu_result = alu_a ^ alu_b;
            default: alu_result = ~alu_a;
        endcase
    end

    assign bus.ALU_out  = alu_result;
    assign bus.ALU_zero = (alu_result == 16'h0000);

endmodule

// File: tb/tb_proc_datapath.sv
// Directed self-checking bench for proc_datapath: fetch, PC wrap/clear, load,
// ALU ops, store with read-during-write, RF same-cycle read, reset mid-load.
module tb_proc_datapath;

    localparam int PC_W = 7;

    logic clk;
    logic Reset;
    int   n_checks;
    int   n_errors;
    logic [15:0] rom [2**PC_W];

    proc_datapath_if #(.PC_W(PC_W)) dp_if ();

    proc_datapath #(.PC_W(PC_W)) u_dut (
        .clk   (clk),
        .Reset (Reset),
        .bus   (dp_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction ROM: word i = 16'h3012 + i*16'h0111
    assign dp_if.I_data = rom[dp_if.I_addr];

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s got=%h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [7:0] a, input logic [15:0] d);
        dp_if.dbg_wr   = 1'b1;
        dp_if.dbg_addr = a;
        dp_if.dbg_data = d;
        step();
        dp_if.dbg_wr   = 1'b0;
    endtask

    task automatic load_rf(input logic [7:0] a, input logic [3:0] r);
        dp_if.D_addr    = a;
        dp_if.RF_s      = 1'b1;
        dp_if.RF_W_en   = 1'b0;
        step();
        dp_if.RF_W_addr = r;
        dp_if.RF_W_en   = 1'b1;
        step();
        dp_if.RF_W_en   = 1'b0;
        dp_if.RF_s      = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < 2**PC_W; i++) rom[i] = 16'h3012 + 16'(i) * 16'h0111;

        Reset            = 1'b1;
        dp_if.PC_clr     = 1'b0;
        dp_if.PC_up      = 1'b0;
        dp_if.IR_Id      = 1'b0;
        dp_if.D_addr     = 8'h00;
        dp_if.D_wr       = 1'b0;
        dp_if.RF_s       = 1'b0;
        dp_if.RF_W_addr  = 4'h0;
        dp_if.RF_W_en    = 1'b0;
        dp_if.RF_Ra_addr = 4'h0;
        dp_if.RF_Rb_addr = 4'h0;
        dp_if.ALU_s0     = 3'b000;
        dp_if.dbg_wr     = 1'b0;
        dp_if.dbg_addr   = 8'h00;
        dp_if.dbg_data   = 16'h0000;
        step();
        step();
        Reset = 1'b0;

        // ---- reset state
        check("rst_iaddr", 16'(dp_if.I_addr), 16'h0000);
        check("rst_ir", dp_if.IR, 16'h0000);
        check("rst_rdata", dp_if.R_data, 16'h0000);
        check("rst_ra", dp_if.Ra_data, 16'h0000);
        check("rst_rb", dp_if.Rb_data, 16'h0000);
        check("rst_alu0", dp_if.ALU_out, 16'h0000);
        check("rst_zero0", 16'(dp_if.ALU_zero), 16'h0001);
        dp_if.ALU_s0 = 3'b111;
        #1;
        check("rst_alu7", dp_if.ALU_out, 16'hFFFF);
        check("rst_zero7", 16'(dp_if.ALU_zero), 16'h0000);
        dp_if.ALU_s0 = 3'b000;

        // ---- fetch, PC wrap, PC clear
        dp_if.IR_Id = 1'b1;
        dp_if.PC_up = 1'b1;
        step();
        dp_if.IR_Id = 1'b0;
        check("fetch_ir", dp_if.IR, 16'h3012);
        check("fetch_pc", 16'(dp_if.I_addr), 16'h0001);
        step();
        step();
        dp_if.PC_up = 1'b0;
        dp_if.IR_Id = 1'b1;
        step();
        dp_if.IR_Id = 1'b0;
        check("fetch3_ir", dp_if.IR, 16'h3345);
        check("pc_hold", 16'(dp_if.I_addr), 16'h0003);
        dp_if.PC_up = 1'b1;
        for (int i = 0; i < 124; i++) step();
        check("pc_max", 16'(dp_if.I_addr), 16'h007F);
        step();
        check("pc_wrap", 16'(dp_if.I_addr), 16'h0000);
        step();
        step();
        dp_if.PC_clr = 1'b1;
        step();
        dp_if.PC_clr = 1'b0;
        dp_if.PC_up  = 1'b0;
        check("pc_clr_wins", 16'(dp_if.I_addr), 16'h0000);

        // ---- load: R_data valid in the second cycle, RF written at its end
        preload(8'h10, 16'h00A5);
        preload(8'h20, 16'h5555);
        preload(8'h01, 16'h0003);
        preload(8'h02, 16'h0005);
        preload(8'h30, 16'h1234);
        preload(8'h40, 16'h1111);
        dp_if.D_addr = 8'h10;
        dp_if.RF_s   = 1'b1;
        step();
        check("load_rdata", dp_if.R_data, 16'h00A5);
        dp_if.RF_W_en   = 1'b1;
        dp_if.RF_W_addr = 4'd2;
        step();
        dp_if.RF_W_en    = 1'b0;
        dp_if.RF_s       = 1'b0;
        dp_if.RF_Ra_addr = 4'd2;
        #1;
        check("load_rf2", dp_if.Ra_data, 16'h00A5);

        // ---- ALU operations with A=3, B=5
        load_rf(8'h01, 4'd1);
        load_rf(8'h02, 4'd2);
        dp_if.RF_Ra_addr = 4'd1;
        dp_if.RF_Rb_addr = 4'd2;
        dp_if.ALU_s0     = 3'b001;
        #1;
        check("alu_add", dp_if.ALU_out, 16'h0008);
        dp_if.RF_W_addr = 4'd3;
        dp_if.RF_W_en   = 1'b1;
        step();
        dp_if.ALU_s0    = 3'b010;
        dp_if.RF_W_addr = 4'd4;
        #1;
        check("alu_sub", dp_if.ALU_out, 16'hFFFE);
        check("alu_sub_nz", 16'(dp_if.ALU_zero), 16'h0000);
        step();
        dp_if.RF_W_en    = 1'b0;
        dp_if.RF_Rb_addr = 4'd3;
        #1;
        check("rf3_add", dp_if.Rb_data, 16'h0008);
        dp_if.RF_Rb_addr = 4'd4;
        #1;
        check("rf4_sub", dp_if.Rb_data, 16'hFFFE);
        dp_if.RF_Rb_addr = 4'd1;
        #1;
        check("sub_eq_val", dp_if.ALU_out, 16'h0000);
        check("sub_eq_zero", 16'(dp_if.ALU_zero), 16'h0001);
        dp_if.RF_Rb_addr = 4'd2;
        dp_if.ALU_s0 = 3'b000; #1; check("alu_zero_op", dp_if.ALU_out, 16'h0000);
        dp_if.ALU_s0 = 3'b011; #1; check("alu_pass_a", dp_if.ALU_out, 16'h0003);
        dp_if.ALU_s0 = 3'b100; #1; check("alu_and", dp_if.ALU_out, 16'h0001);
        dp_if.ALU_s0 = 3'b101; #1; check("alu_or", dp_if.ALU_out, 16'h0007);
        dp_if.ALU_s0 = 3'b110; #1; check("alu_xor", dp_if.ALU_out, 16'h0006);
        dp_if.ALU_s0 = 3'b111; #1; check("alu_not", dp_if.ALU_out, 16'hFFFC);

        // ---- register 0 is writable
        dp_if.ALU_s0     = 3'b011;
        dp_if.RF_Ra_addr = 4'd3;
        dp_if.RF_W_addr  = 4'd0;
        dp_if.RF_W_en    = 1'b1;
        step();
        dp_if.RF_W_en    = 1'b0;
        dp_if.RF_Rb_addr = 4'd0;
        #1;
        check("rf0_write", dp_if.Rb_data, 16'h0008);

        // ---- store with read-during-write; simultaneous preload dropped
        dp_if.D_addr     = 8'h20;
        dp_if.RF_Ra_addr = 4'd3;
        dp_if.D_wr       = 1'b1;
        dp_if.dbg_wr     = 1'b1;
        dp_if.dbg_addr   = 8'h20;
        dp_if.dbg_data   = 16'hFFFF;
        step();
        dp_if.D_wr   = 1'b0;
        dp_if.dbg_wr = 1'b0;
        check("st_rdw_old", dp_if.R_data, 16'h5555);
        step();
        check("st_new", dp_if.R_data, 16'h0008);
        step();
        check("st_dbg_drop", dp_if.R_data, 16'h0008);

        // ---- RF write and read of the same address in one cycle
        dp_if.D_addr = 8'h30;
        dp_if.RF_s   = 1'b1;
        step();
        dp_if.RF_W_addr  = 4'd5;
        dp_if.RF_Ra_addr = 4'd5;
        dp_if.RF_W_en    = 1'b1;
        #1;
        check("rf_same_old", dp_if.Ra_data, 16'h0000);
        step();
        dp_if.RF_W_en = 1'b0;
        dp_if.RF_s    = 1'b0;
        check("rf_same_new", dp_if.Ra_data, 16'h1234);

        // ---- reset in the second cycle of a load
        dp_if.PC_up = 1'b1;
        dp_if.IR_Id = 1'b1;
        step();
        dp_if.PC_up = 1'b0;
        dp_if.IR_Id = 1'b0;
        dp_if.D_addr = 8'h10;
        dp_if.RF_s   = 1'b1;
        step();
        Reset            = 1'b1;
        dp_if.RF_W_en    = 1'b1;
        dp_if.RF_W_addr  = 4'd2;
        dp_if.RF_Ra_addr = 4'd3;
        dp_if.D_wr       = 1'b1;
        dp_if.dbg_wr     = 1'b1;
        dp_if.dbg_addr   = 8'h40;
        dp_if.dbg_data   = 16'hBEEF;
        step();
        Reset            = 1'b0;
        dp_if.RF_W_en    = 1'b0;
        dp_if.RF_s       = 1'b0;
        dp_if.D_wr       = 1'b0;
        dp_if.dbg_wr     = 1'b0;
        dp_if.RF_Ra_addr = 4'd2;
        #1;
        check("rst_mid_rf2", dp_if.Ra_data, 16'h0000);
        check("rst_mid_pc", 16'(dp_if.I_addr), 16'h0000);
        check("rst_mid_ir", dp_if.IR, 16'h0000);
        check("rst_mid_rdata", dp_if.R_data, 16'h0000);
        step();
        check("rst_mem_kept", dp_if.R_data, 16'h00A5);
        dp_if.D_addr = 8'h40;
        step();
        check("rst_dbg_block", dp_if.R_data, 16'h1111);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
